// File: rtl/neuron_sequencer_if.sv
// Control, config and memory-side bus of the neuron sequencer.
// The sequencer owns the address/result side; host and memories sit on the slave side.
interface neuron_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              CfgWE;
    logic [2:0]        CfgAddr;
    logic [DATA_W-1:0] CfgData;
    logic              StartOperation;
    logic              ReadyForNextOp;
    logic [ADDR_W-1:0] IdxAddr;
    logic [DATA_W-1:0] IdxData;
    logic [ADDR_W-1:0] WtAddr;
    logic [DATA_W-1:0] WtData;
    logic [ADDR_W-1:0] InAddr;
    logic [DATA_W-1:0] InData;
    logic              ResWE;
    logic [ADDR_W-1:0] ResAddr;
    logic [DATA_W-1:0] ResData;
    logic              Done;

    modport master (
        input  CfgWE, CfgAddr, CfgData, StartOperation, IdxData, WtData, InData,
        output ReadyForNextOp, IdxAddr, WtAddr, InAddr, ResWE, ResAddr, ResData, Done
    );

    modport slave (
        output CfgWE, CfgAddr, CfgData, StartOperation, IdxData, WtData, InData,
        input  ReadyForNextOp, IdxAddr, WtAddr, InAddr, ResWE, ResAddr, ResData, Done
    );
endinterface

// File: rtl/neuron_sequencer.sv
// Sparse-indexed dot-product sequencer: per neuron it gathers inputs through an index
// table, multiplies by weights, accumulates, applies an activation and writes one result.
module neuron_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst_n,
    neuron_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, IDX, IN, MAC, ACT, WR, DONE} state_t;

    localparam logic signed [DATA_W-1:0] maxV   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] minV   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] posLim = DATA_W'(1 << FRAC_W);
    localparam logic signed [DATA_W-1:0] negLim = -posLim;

    state_t state;

    logic [ADDR_W-1:0] inOffset, idxOffset, wtOffset, dest;
    logic [CNT_W-1:0]  numOps, numNeurons;
    logic [1:0]        actSel;

    logic [ADDR_W-1:0] idxBase, wtBase, destBase;
    logic [CNT_W-1:0]  opCnt, nrnCnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] wtQ;

    logic [ADDR_W-1:0] idxAddrQ, wtAddrQ, inAddrQ, resAddrQ;
    logic [DATA_W-1:0] resDataQ;
    logic              resWeQ, doneQ, readyQ;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [DATA_W-1:0]   sat, actOut;
    logic [ADDR_W-1:0]          inAddrNext;
    logic [CNT_W:0]             opNext, nrnNext, nrnLimit;

    always_comb begin
        prod       = $signed(bus.InData) * wtQ;
        shifted    = acc >>> FRAC_W;
        inAddrNext = inOffset + ADDR_W'(bus.IdxData);
        opNext     = {1'b0, opCnt} + (CNT_W+1)'(1);
        nrnNext    = {1'b0, nrnCnt} + (CNT_W+1)'(1);
        nrnLimit   = (numNeurons == '0) ? (CNT_W+1)'(1) : {1'b0, numNeurons};
        // Fits in DATA_W only when every bit above the result sign matches it.
        if ((&shifted[ACC_W-1:DATA_W-1]) || !(|shifted[ACC_W-1:DATA_W-1]))
            sat = shifted[DATA_W-1:0];
        else
            sat = shifted[ACC_W-1] ? minV : maxV;
        case (actSel)
            2'd1:    actOut = sat[DATA_W-1] ? '0 : sat;
            2'd2:    actOut = (sat > posLim) ? posLim : ((sat < negLim) ? negLim : sat);
            default: actOut = sat;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            inOffset   <= '0;
            idxOffset  <= '0;
            wtOffset   <= '0;
            dest       <= '0;
            numOps     <= '0;
            numNeurons <= '0;
            actSel     <= '0;
            idxBase    <= '0;
            wtBase     <= '0;
            destBase   <= '0;
            opCnt      <= '0;
            nrnCnt     <= '0;
            acc        <= '0;
            wtQ        <= '0;
            idxAddrQ   <= '0;
            wtAddrQ    <= '0;
            inAddrQ    <= '0;
            resAddrQ   <= '0;
            resDataQ   <= '0;
            resWeQ     <= 1'b0;
            doneQ      <= 1'b0;
            readyQ     <= 1'b1;
        end else begin
            resWeQ <= 1'b0;
            doneQ  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.CfgWE) begin
                        case (bus.CfgAddr)
                            3'd0:    inOffset   <= ADDR_W'(bus.CfgData);
                            3'd1:    idxOffset  <= ADDR_W'(bus.CfgData);
                            3'd2:    wtOffset   <= ADDR_W'(bus.CfgData);
                            3'd3:    numOps     <= CNT_W'(bus.CfgData);
                            3'd4:    dest       <= ADDR_W'(bus.CfgData);
                            3'd5:    actSel     <= bus.CfgData[1:0];
                            3'd6:    numNeurons <= CNT_W'(bus.CfgData);
                            default: ;
                        endcase
                    end
                    if (bus.StartOperation) begin
                        acc      <= '0;
                        opCnt    <= '0;
                        nrnCnt   <= '0;
                        idxBase  <= idxOffset;
                        wtBase   <= wtOffset;
                        destBase <= dest;
                        readyQ   <= 1'b0;
                        if (numOps == '0) begin
                            state <= ACT;
                        end else begin
                            idxAddrQ <= idxOffset;
                            wtAddrQ  <= wtOffset;
                            state    <= IDX;
                        end
                    end
                end
                IDX: state <= IN;
                IN: begin
                    wtQ     <= bus.WtData;
                    inAddrQ <= inAddrNext;
                    state   <= MAC;
                end
                MAC: begin
                    acc   <= acc + ACC_W'(prod);
                    opCnt <= opNext[CNT_W-1:0];
                    if (opNext < {1'b0, numOps}) begin
                        idxAddrQ <= idxBase + ADDR_W'(opNext[CNT_W-1:0]);
                        wtAddrQ  <= wtBase + ADDR_W'(opNext[CNT_W-1:0]);
                        state    <= IDX;
                    end else begin
                        state <= ACT;
                    end
                end
                ACT: begin
                    resDataQ <= actOut;
                    resAddrQ <= destBase;
                    resWeQ   <= 1'b1;
                    state    <= WR;
                end
                WR: begin
                    nrnCnt <= nrnNext[CNT_W-1:0];
                    if (nrnNext < nrnLimit) begin
                        idxBase  <= idxBase + ADDR_W'(numOps);
                        wtBase   <= wtBase + ADDR_W'(numOps);
                        destBase <= destBase + ADDR_W'(1);
                        acc      <= '0;
                        opCnt    <= '0;
                        if (numOps == '0) begin
                            state <= ACT;
                        end else begin
                            idxAddrQ <= idxBase + ADDR_W'(numOps);
                            wtAddrQ  <= wtBase + ADDR_W'(numOps);
                            state    <= IDX;
                        end
                    end else begin
                        doneQ <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    readyQ <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The input address depends on the index word that only arrives during IN.
    assign bus.InAddr         = (state == IN) ? inAddrNext : inAddrQ;
    assign bus.IdxAddr        = idxAddrQ;
    assign bus.WtAddr         = wtAddrQ;
    assign bus.ResWE          = resWeQ;
    assign bus.ResAddr        = resAddrQ;
    assign bus.ResData        = resDataQ;
    assign bus.Done           = doneQ;
    assign bus.ReadyForNextOp = readyQ;
endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with behavioural 1-cycle-latency memories.
module tb_neuron_sequencer;
    logic clk, rst_n;
    int checks = 0;
    int failures = 0;

    neuron_sequencer_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    neuron_sequencer #(.DATA_W(16), .ADDR_W(16), .FRAC_W(8), .ACC_W(40), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] idxMem[256];
    logic [15:0] wtMem[256];
    logic [15:0] inMem[256];

    always @(posedge clk) begin
        bus.IdxData <= idxMem[bus.IdxAddr[7:0]];
        bus.WtData  <= wtMem[bus.WtAddr[7:0]];
        bus.InData  <= inMem[bus.InAddr[7:0]];
    end

    int weCount, doneCount, firstWe, doneCycle, readyCycle, seen;
    logic [15:0] weAddr[4], weData[4];
    int weCyc[4];
    logic [15:0] idxLog[64], wtLog[64], inLog[64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] a, input logic [15:0] d);
        bus.CfgWE = 1'b1; bus.CfgAddr = a; bus.CfgData = d;
        @(negedge clk);
        bus.CfgWE = 1'b0;
    endtask

    task automatic setup018(input logic [15:0] act);
        cfg(3'd0, 16'd1); cfg(3'd1, 16'd1); cfg(3'd2, 16'd1);
        cfg(3'd4, 16'd1); cfg(3'd3, 16'd2); cfg(3'd5, act);
    endtask

    // Cycle 1 is the first cycle after the edge that accepts StartOperation.
    task automatic runOp(input bit pokeBusy);
        weCount = 0; doneCount = 0; firstWe = -1; doneCycle = -1; readyCycle = -1;
        bus.StartOperation = 1'b1;
        @(negedge clk);
        bus.StartOperation = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            idxLog[c] = bus.IdxAddr; wtLog[c] = bus.WtAddr; inLog[c] = bus.InAddr;
            if (bus.ResWE) begin
                if (weCount < 4) begin
                    weAddr[weCount] = bus.ResAddr; weData[weCount] = bus.ResData; weCyc[weCount] = c;
                end
                if (firstWe < 0) firstWe = c;
                weCount++;
            end
            if (bus.Done) begin doneCount++; doneCycle = c; end
            if (bus.ReadyForNextOp) begin readyCycle = c; break; end
            if (pokeBusy && c == 2) begin
                bus.CfgWE = 1'b1; bus.CfgAddr = 3'd4; bus.CfgData = 16'd9; bus.StartOperation = 1'b1;
            end
            if (pokeBusy && c == 3) begin
                bus.CfgWE = 1'b0; bus.StartOperation = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin idxMem[i] = '0; wtMem[i] = '0; inMem[i] = '0; end
        rst_n = 1'b0;
        bus.CfgWE = 1'b0; bus.CfgAddr = '0; bus.CfgData = '0; bus.StartOperation = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.ReadyForNextOp, 1);
        chk("rst_we", bus.ResWE, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_idxaddr", bus.IdxAddr, 0);
        chk("rst_resdata", bus.ResData, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single neuron, 1.0*1.0 + 2.0*2.0 = 5.0
        idxMem[1] = 16'd0; idxMem[2] = 16'd1;
        inMem[1] = 16'h0100; inMem[2] = 16'h0200;
        wtMem[1] = 16'h0100; wtMem[2] = 16'h0200;
        setup018(16'd0);
        runOp(1'b0);
        chk("r18_we_cycle", firstWe, 8);
        chk("r18_we_count", weCount, 1);
        chk("r18_resaddr", weAddr[0], 16'h0001);
        chk("r18_resdata", weData[0], 16'h0500);
        chk("r18_done_cycle", doneCycle, 9);
        chk("r18_done_count", doneCount, 1);
        chk("r18_ready_cycle", readyCycle, 10);
        chk("r18_idxaddr_op0", idxLog[1], 16'd1);
        chk("r18_idxaddr_op1", idxLog[4], 16'd2);
        chk("r18_inaddr_op0", inLog[2], 16'd1);
        chk("r18_inaddr_op1", inLog[5], 16'd2);

        // 1.0 - 4.0 = -3.0 through each activation
        wtMem[2] = 16'hFE00;
        cfg(3'd5, 16'd1); runOp(1'b0);
        chk("r19_relu", weData[0], 16'h0000);
        cfg(3'd5, 16'd0); runOp(1'b0);
        chk("r19_linear", weData[0], 16'hFD00);
        cfg(3'd5, 16'd2); runOp(1'b0);
        chk("r19_clamp_neg", weData[0], 16'hFF00);
        cfg(3'd5, 16'd3); runOp(1'b0);
        chk("r19_sel3_linear", weData[0], 16'hFD00);
        wtMem[2] = 16'h0200;
        cfg(3'd5, 16'd2); runOp(1'b0);
        chk("clamp_pos", weData[0], 16'h0100);

        // saturation both directions
        cfg(3'd3, 16'd1); cfg(3'd5, 16'd0);
        inMem[1] = 16'h7FFF; wtMem[1] = 16'h7FFF;
        runOp(1'b0);
        chk("r20_sat_pos", weData[0], 16'h7FFF);
        chk("r20_we_cycle", firstWe, 5);
        wtMem[1] = 16'h8000;
        runOp(1'b0);
        chk("sat_neg", weData[0], 16'h8000);
        inMem[1] = 16'h0100; wtMem[1] = 16'h0100;

        // config write and start while busy must be ignored
        cfg(3'd3, 16'd2);
        runOp(1'b1);
        chk("busy_we_cycle", firstWe, 8);
        chk("busy_resaddr", weAddr[0], 16'h0001);
        chk("busy_resdata", weData[0], 16'h0500);
        chk("busy_done_count", doneCount, 1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ResWE || bus.Done || !bus.ReadyForNextOp) seen++;
        end
        chk("busy_no_restart", seen, 0);

        // zero ops: result is zero; Dest still 1 proves the busy write was dropped
        cfg(3'd3, 16'd0);
        runOp(1'b0);
        chk("r22_we_cycle", firstWe, 2);
        chk("r22_resdata", weData[0], 16'h0000);
        chk("r22_resaddr", weAddr[0], 16'h0001);
        chk("r22_done_cycle", doneCycle, 3);

        // two-neuron batch
        idxMem[3] = 16'd1; idxMem[4] = 16'd0;
        wtMem[3] = 16'h0300; wtMem[4] = 16'h0100;
        cfg(3'd3, 16'd2); cfg(3'd6, 16'd2); cfg(3'd4, 16'd4);
        runOp(1'b0);
        chk("r21_we_count", weCount, 2);
        chk("r21_addr0", weAddr[0], 16'd4);
        chk("r21_addr1", weAddr[1], 16'd5);
        chk("r21_data0", weData[0], 16'h0500);
        chk("r21_data1", weData[1], 16'h0700);
        chk("r21_we1_cycle", weCyc[1], 16);
        chk("r21_idx_n1op0", idxLog[9], 16'd3);
        chk("r21_idx_n1op1", idxLog[12], 16'd4);
        chk("r21_wt_n1op0", wtLog[9], 16'd3);
        chk("r21_wt_n1op1", wtLog[12], 16'd4);
        chk("r21_done_count", doneCount, 1);
        chk("r21_done_cycle", doneCycle, 17);

        // reset during MAC of a batch
        bus.StartOperation = 1'b1;
        @(negedge clk);
        bus.StartOperation = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("r23_ready", bus.ReadyForNextOp, 1);
        chk("r23_we", bus.ResWE, 0);
        chk("r23_done", bus.Done, 0);
        chk("r23_idxaddr", bus.IdxAddr, 0);
        chk("r23_wtaddr", bus.WtAddr, 0);
        chk("r23_inaddr", bus.InAddr, 0);
        chk("r23_resaddr", bus.ResAddr, 0);
        chk("r23_resdata", bus.ResData, 0);
        seen = 0;
        repeat (3) begin @(negedge clk); if (bus.ResWE || bus.Done) seen++; end
        rst_n = 1'b1;
        repeat (20) begin @(negedge clk); if (bus.ResWE || bus.Done) seen++; end
        chk("r23_no_write", seen, 0);
        chk("r23_ready_after", bus.ReadyForNextOp, 1);

        setup018(16'd0);
        runOp(1'b0);
        chk("r23_rerun_cycle", firstWe, 8);
        chk("r23_rerun_count", weCount, 1);
        chk("r23_rerun_addr", weAddr[0], 16'h0001);
        chk("r23_rerun_data", weData[0], 16'h0500);
        chk("r23_rerun_ready", readyCycle, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 Parameters: DATA_W=16 (operand/result width); ADDR_W=16 (memory address width); FRAC_W=8 (fraction bits, signed fixed point); ACC_W=40 (accumulator width, SHALL be >= 2*DATA_W); CNT_W=16 (op/neuron counter width).
REQ-002 Ports SHALL be exactly:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- CfgWE  in  1  config register write strobe
- CfgAddr  in  3  config register select
- CfgData  in  DATA_W  config write data
- StartOperation  in  1  start request
- ReadyForNextOp  out  1  idle, start accepted
- IdxAddr  out  ADDR_W  index memory read address
- IdxData  in  DATA_W  index memory data, 1-cycle read latency
- WtAddr  out  ADDR_W  weight memory read address
- WtData  in  DATA_W  weight data, 1-cycle latency
- InAddr  out  ADDR_W  input memory read address
- InData  in  DATA_W  input data, 1-cycle latency
- ResWE  out  1  result write strobe
- ResAddr  out  ADDR_W  result write address
- ResData  out  DATA_W  result value
- Done  out  1  one-cycle pulse, batch complete

Function
REQ-003 Config map (CfgAddr): 0 InOffset, 1 IdxOffset, 2 WtOffset, 3 NumOps, 4 Dest, 5 ActSel (bits[1:0]), 6 NumNeurons; 7 ignored.
REQ-004 Config writes SHALL take effect at the CfgWE edge only in IDLE; writes while busy SHALL be ignored.
REQ-005 FSM states: IDLE, IDX, IN, MAC, ACT, WR, plus DONE.
REQ-006 IDLE: ReadyForNextOp=1; StartOperation=1 at an edge -> acc=0, op i=0, neuron n=0, working copies of IdxOffset/WtOffset/Dest loaded; next IDX, or ACT if NumOps=0.
REQ-007 StartOperation outside IDLE SHALL be ignored; ReadyForNextOp=0 in every non-IDLE state.
REQ-008 IDX: IdxAddr=IdxBase+i, WtAddr=WtBase+i; next IN.
REQ-009 IN: InAddr=InOffset+IdxData (uses index returned from IDX read); weight captured; next MAC.
REQ-010 MAC: acc += sign-extended (InData * captured weight), full 2*DATA_W signed product; i++; next IDX if i<NumOps else ACT.
REQ-011 Address sums SHALL wrap modulo 2^ADDR_W; acc SHALL wrap modulo 2^ACC_W.
REQ-012 ACT: r = acc arithmetic-shifted right FRAC_W, saturated to signed DATA_W; ActSel 0/3: r; 1 (ReLU): negative->0; 2 (clamp): limit to [-(1<<FRAC_W), +(1<<FRAC_W)]; registered into ResData; next WR.
REQ-013 WR: ResWE=1 one cycle, ResAddr=DestBase, ResData=r; n++; if n<max(NumNeurons,1): IdxBase+=NumOps, WtBase+=NumOps, DestBase+=1, acc=0, i=0, next IDX (or ACT if NumOps=0); else DONE.
REQ-014 DONE: Done=1 one cycle; next IDLE.
REQ-015 Latency per neuron SHALL be 3*NumOps+2 cycles from IDX/ACT entry to end of WR; NumNeurons=0 SHALL behave as 1.
REQ-016 Read addresses not in use SHALL hold last value; ResWE and Done SHALL be 0 except in WR/DONE.

Reset
REQ-017 rst_n=0 SHALL immediately force IDLE, all config registers, counters, acc, addresses, ResData to 0, ResWE=0, Done=0, ReadyForNextOp=1, including mid-operation; no partial write SHALL occur.

Verification
REQ-018 InOffset=1, IdxOffset=1, WtOffset=1, Dest=1, NumOps=2, ActSel=0; In[1..2]=0x0100,0x0200; Idx[1..2]=0,1; Wt[1..2]=0x0100,0x0200; start -> single ResWE at cycle 8, ResAddr=1, ResData=0x0500, Done next cycle, ReadyForNextOp=1 after.
REQ-019 Same with Wt[2]=0xFE00 (-2.0), ActSel=1 -> ResData=0x0000; ActSel=0 -> 0xFD00; ActSel=2 -> 0xFF00.
REQ-020 Saturation: NumOps=1, In=0x7FFF, Wt=0x7FFF, ActSel=0 -> ResData=0x7FFF.
REQ-021 Batch: NumNeurons=2, NumOps=2, IdxOffset=1, WtOffset=1, Dest=4 -> writes at ResAddr 4 then 5, second neuron reads Idx/Wt addresses 3,4; one Done pulse.
REQ-022 NumOps=0, start -> ResWE at cycle 2 with ResData=0x0000; config write and StartOperation while busy ignored.
REQ-023 rst_n low during MAC of batch -> no ResWE, all outputs zero, ReadyForNextOp=1; subsequent start after reconfig runs REQ-018 correctly.
